// File: rtl/seg_display_scheduler.sv
// -----------------------------------------------------------------------------
// seg_display_scheduler
//
// Four-digit seven-segment display controller. A 14-bit binary value is
// captured on a load strobe, clipped to 9999 and converted to packed BCD by a
// sequential shift-add-3 engine (one step per clock, 14 steps). The committed
// BCD value is scanned across the four digits and gated by a value-dependent
// blink policy (steady / slow blink / fast blink for zero).
//
// Ports
//   i_clk       system clock, single domain
//   i_rst_n     asynchronous active-low reset, synchronous release expected
//   i_val_in    binary value to display
//   i_val_load  1-cycle strobe: capture i_val_in and start a conversion
//   o_busy      conversion in progress; loads are dropped while high
//   o_dig_en    one-hot digit enable, [3]=thousands .. [0]=units, active-high
//   o_seg       segment drive, [0]=A .. [6]=G, active-high
//
// state    | meaning
// ---------+----------------------------------------------------------------
// ST_IDLE  | waiting for a load strobe; display shows last committed value
// ST_SHIFT | shift-add-3 in progress, 14 steps, commit on the last one
// -----------------------------------------------------------------------------
module seg_display_scheduler #(
   parameter int SCAN_DIV = 100000,
   parameter int HALF_DIV = 25000000,
   parameter int THRESH   = 180
) (
   input  logic        i_clk,
   input  logic        i_rst_n,
   input  logic [13:0] i_val_in,
   input  logic        i_val_load,
   output logic        o_busy,
   output logic [3:0]  o_dig_en,
   output logic [6:0]  o_seg
);

   localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int HALF_W = (HALF_DIV > 1) ? $clog2(HALF_DIV) : 1;

   typedef enum logic {
      ST_IDLE,
      ST_SHIFT
   } state_t;

   typedef enum logic [1:0] {
      MODE_ZERO,
      MODE_SLOW,
      MODE_STEADY
   } mode_t;

   function automatic mode_t mode_of(input logic [13:0] v);
      if (v == 14'd0)
         return MODE_ZERO;
      else if (int'(v) >= THRESH)
         return MODE_STEADY;
      else
         return MODE_SLOW;
   endfunction

   function automatic logic [6:0] seg_pat(input logic [3:0] d);
      logic [6:0] p;
      case (d)
         4'd0:    p = 7'b0111111;
         4'd1:    p = 7'b0000110;
         4'd2:    p = 7'b1011011;
         4'd3:    p = 7'b1001111;
         4'd4:    p = 7'b1100110;
         4'd5:    p = 7'b1101101;
         4'd6:    p = 7'b1111101;
         4'd7:    p = 7'b0000111;
         4'd8:    p = 7'b1111111;
         4'd9:    p = 7'b1101111;
         default: p = 7'b0000000;
      endcase
      return p;
   endfunction

   function automatic logic [3:0] add3(input logic [3:0] n);
      return (n >= 4'd5) ? (n + 4'd3) : n;
   endfunction

   // conversion engine
   state_t      r_state;
   logic [3:0]  r_shift_cnt;
   logic [13:0] r_shift_val;
   logic [15:0] r_bcd_work;
   logic [13:0] r_lat_val;
   logic        r_busy;

   // committed display value
   logic [15:0] r_bcd;
   logic [13:0] r_value;

   // blink
   logic [HALF_W-1:0] r_half_div;
   logic              r_half_odd;
   logic              r_phase;

   // scan
   logic [SCAN_W-1:0] r_scan_div;
   logic [1:0]        r_idx;

   logic [13:0] w_val_clip;
   logic [15:0] w_bcd_adj;
   logic [15:0] w_bcd_step;
   logic        w_commit;
   mode_t       w_mode_cur;
   mode_t       w_mode_new;
   logic        w_half_tc;
   logic        w_scan_tc;
   logic [3:0]  w_nib;
   logic        w_blank;

   assign w_val_clip = (i_val_in > 14'd9999) ? 14'd9999 : i_val_in;

   assign w_bcd_adj  = {add3(r_bcd_work[15:12]), add3(r_bcd_work[11:8]),
                        add3(r_bcd_work[7:4]),   add3(r_bcd_work[3:0])};
   assign w_bcd_step = {w_bcd_adj[14:0], r_shift_val[13]};

   assign w_commit   = (r_state == ST_SHIFT) && (r_shift_cnt == 4'd13);
   assign w_mode_cur = mode_of(r_value);
   assign w_mode_new = mode_of(r_lat_val);

   assign w_half_tc  = (r_half_div == HALF_W'(HALF_DIV - 1));
   assign w_scan_tc  = (r_scan_div == SCAN_W'(SCAN_DIV - 1));

   assign o_busy = r_busy;

   // Converter: the BCD result and the binary value it came from are
   // committed on the same edge so blink mode and digits never disagree.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_state     <= ST_IDLE;
         r_shift_cnt <= 4'd0;
         r_shift_val <= 14'd0;
         r_bcd_work  <= 16'd0;
         r_lat_val   <= 14'd0;
         r_busy      <= 1'b0;
         r_bcd       <= 16'd0;
         r_value     <= 14'd0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (i_val_load) begin
                  r_lat_val   <= w_val_clip;
                  r_shift_val <= w_val_clip;
                  r_bcd_work  <= 16'd0;
                  r_shift_cnt <= 4'd0;
                  r_busy      <= 1'b1;
                  r_state     <= ST_SHIFT;
               end
            end
            ST_SHIFT: begin
               r_bcd_work  <= w_bcd_step;
               r_shift_val <= {r_shift_val[12:0], 1'b0};
               r_shift_cnt <= r_shift_cnt + 4'd1;
               if (w_commit) begin
                  r_bcd   <= w_bcd_step;
                  r_value <= r_lat_val;
                  r_busy  <= 1'b0;
                  r_state <= ST_IDLE;
               end
            end
            default: begin
               r_state <= ST_IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   // Blink phase. A commit that changes mode restarts the pattern with the
   // display on; a commit into the same mode leaves the running phase alone.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_half_div <= '0;
         r_half_odd <= 1'b0;
         r_phase    <= 1'b1;
      end else if (w_commit && (w_mode_new != w_mode_cur)) begin
         r_half_div <= '0;
         r_half_odd <= 1'b0;
         r_phase    <= 1'b1;
      end else begin
         if (w_half_tc)
            r_half_div <= '0;
         else
            r_half_div <= r_half_div + 1'b1;

         case (w_mode_cur)
            MODE_ZERO: begin
               if (w_half_tc)
                  r_phase <= ~r_phase;
            end
            MODE_SLOW: begin
               // toggle on every second half-tick
               if (w_half_tc) begin
                  r_half_odd <= ~r_half_odd;
                  if (r_half_odd)
                     r_phase <= ~r_phase;
               end
            end
            default: r_phase <= 1'b1;
         endcase
      end
   end

   // Digit scan, thousands first; idx wraps 0 -> 3 by 2-bit underflow.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_scan_div <= '0;
         r_idx      <= 2'd3;
      end else if (w_scan_tc) begin
         r_scan_div <= '0;
         r_idx      <= r_idx - 2'd1;
      end else begin
         r_scan_div <= r_scan_div + 1'b1;
      end
   end

   assign w_nib = r_bcd[{r_idx, 2'b00} +: 4];

   // Leading-zero blanking: a digit is dark when it and every digit above it
   // are zero. Units is never blanked.
   always_comb begin
      w_blank = 1'b0;
      case (r_idx)
         2'd3:    w_blank = (r_bcd[15:12] == 4'd0);
         2'd2:    w_blank = (r_bcd[15:8]  == 8'd0);
         2'd1:    w_blank = (r_bcd[15:4]  == 12'd0);
         default: w_blank = 1'b0;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_dig_en <= 4'b0000;
         o_seg    <= 7'b0000000;
      end else begin
         o_dig_en <= r_phase ? (4'b0001 << r_idx) : 4'b0000;
         o_seg    <= w_blank ? 7'b0000000 : seg_pat(w_nib);
      end
   end

endmodule
